// File: rtl/udisk_bus_acquire.sv
// UNIBUS bus acquisition for a disk controller: arbitrates NPR (DMA tenure)
// and BR4/BR5 (interrupt vector) requests, runs the SACK/BBSY handshake and
// forwards unused grants downstream.
module udisk_bus_acquire #(
  parameter int GRANT_TMO = 1000,
  parameter int DESKEW    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  // local requests
  input  logic        req_npr,
  input  logic        req_intr,
  input  logic        intr_level,
  input  logic [15:0] intr_vector,
  // `release` is a reserved word in SystemVerilog, hence release_req
  input  logic        release_req,
  // UNIBUS receivers (asynchronous to CLK)
  input  logic        BBSY_IN,
  input  logic        SSYN_IN,
  input  logic        INIT_IN,
  input  logic        NPG_IN,
  input  logic        BG4_IN,
  input  logic        BG5_IN,
  // UNIBUS drivers
  output logic        NPR_OUT,
  output logic        BR4_OUT,
  output logic        BR5_OUT,
  output logic        SACK_OUT,
  output logic        BBSY_OUT,
  output logic        INTR_OUT,
  // grants passed to the next device on the chain
  output logic        NPG_OUT,
  output logic        BG4_OUT,
  output logic        BG5_OUT,
  // vector path and status
  output logic [15:0] vec_data,
  output logic        vec_en,
  output logic        granted,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SACK    = 3'd2,
    S_WAITBUS = 3'd3,
    S_MASTER  = 3'd4,
    S_VEC     = 3'd5,
    S_INTR    = 3'd6
  } state_t;

  // Last REQ cycle before abort, and last VEC cycle of the deskew window.
  localparam logic [15:0] TMO_LAST = 16'(GRANT_TMO - 1);
  localparam logic [15:0] DSK_LAST = 16'(DESKEW - 1);

  state_t      state;
  logic [15:0] cnt;

  // Pending requests; interrupt level/vector are captured with the pulse so a
  // later req_intr cannot disturb a vector already on the bus.
  logic        npr_pend;
  logic        intr_pend;
  logic        pend_level;
  logic [15:0] pend_vec;

  // What the current transaction is: NPR, or BR at cur_level.
  logic        cur_npr;
  logic        cur_level;

  // Two-flop synchronizer, bit order {BG5, BG4, NPG, INIT, SSYN, BBSY}.
  logic [5:0]  sync_q1;
  logic [5:0]  sync_q2;

  logic        bbsy_s;
  logic        ssyn_s;
  logic        init_s;
  logic        npg_s;
  logic        bg4_s;
  logic        bg5_s;
  logic        grant_s;
  logic        req_active;

  // Synchronize all asynchronous bus receivers before any decision uses them.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {BG5_IN, BG4_IN, NPG_IN, INIT_IN, SSYN_IN, BBSY_IN};
      sync_q2 <= sync_q1;
    end
  end

  assign bbsy_s = sync_q2[0];
  assign ssyn_s = sync_q2[1];
  assign init_s = sync_q2[2];
  assign npg_s  = sync_q2[3];
  assign bg4_s  = sync_q2[4];
  assign bg5_s  = sync_q2[5];

  // The grant line that answers the request currently being made.
  assign grant_s = cur_npr ? npg_s : (cur_level ? bg5_s : bg4_s);

  // Grants are blocked only while we are asking for (or acknowledging) that
  // very grant; otherwise they ripple straight through, including in reset.
  assign req_active = (state == S_REQ) || (state == S_SACK);
  assign NPG_OUT    = NPG_IN & ~(req_active &  cur_npr);
  assign BG4_OUT    = BG4_IN & ~(req_active & ~cur_npr & ~cur_level);
  assign BG5_OUT    = BG5_IN & ~(req_active & ~cur_npr &  cur_level);

  // Main sequencer; every bus output is registered alongside the state so it
  // is glitch-free and is cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      npr_pend   <= 1'b0;
      intr_pend  <= 1'b0;
      pend_level <= 1'b0;
      pend_vec   <= '0;
      cur_npr    <= 1'b0;
      cur_level  <= 1'b0;
      vec_data   <= '0;
      NPR_OUT    <= 1'b0;
      BR4_OUT    <= 1'b0;
      BR5_OUT    <= 1'b0;
      SACK_OUT   <= 1'b0;
      BBSY_OUT   <= 1'b0;
      INTR_OUT   <= 1'b0;
      vec_en     <= 1'b0;
      granted    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;

      // Pulses are remembered regardless of state and served from IDLE.
      if (req_npr) npr_pend <= 1'b1;
      if (req_intr) begin
        intr_pend  <= 1'b1;
        pend_level <= intr_level;
        pend_vec   <= intr_vector;
      end

      if (init_s) begin
        // Bus INIT aborts everything; timeout is deliberately left alone.
        state     <= S_IDLE;
        npr_pend  <= 1'b0;
        intr_pend <= 1'b0;
        NPR_OUT   <= 1'b0;
        BR4_OUT   <= 1'b0;
        BR5_OUT   <= 1'b0;
        SACK_OUT  <= 1'b0;
        BBSY_OUT  <= 1'b0;
        INTR_OUT  <= 1'b0;
        vec_en    <= 1'b0;
        granted   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // NPR beats BR; the loser stays pending.
            if (npr_pend) begin
              state    <= S_REQ;
              npr_pend <= req_npr;
              cur_npr  <= 1'b1;
              cnt      <= '0;
              timeout  <= 1'b0;
              NPR_OUT  <= 1'b1;
            end else if (intr_pend) begin
              state     <= S_REQ;
              intr_pend <= req_intr;
              cur_npr   <= 1'b0;
              cur_level <= pend_level;
              vec_data  <= pend_vec;
              cnt       <= '0;
              timeout   <= 1'b0;
              BR4_OUT   <= ~pend_level;
              BR5_OUT   <= pend_level;
            end
          end

          S_REQ: begin
            cnt <= cnt + 16'd1;
            if (grant_s) begin
              // Request line falls in the same cycle SACK rises.
              state    <= S_SACK;
              NPR_OUT  <= 1'b0;
              BR4_OUT  <= 1'b0;
              BR5_OUT  <= 1'b0;
              SACK_OUT <= 1'b1;
            end else if (cnt == TMO_LAST) begin
              // Nobody granted within GRANT_TMO cycles: give up quietly.
              state   <= S_IDLE;
              NPR_OUT <= 1'b0;
              BR4_OUT <= 1'b0;
              BR5_OUT <= 1'b0;
              timeout <= 1'b1;
            end
          end

          S_SACK: begin
            // Hold SACK until the arbiter withdraws the grant.
            if (!grant_s) state <= S_WAITBUS;
          end

          S_WAITBUS: begin
            // Previous master must be fully off the bus before we take BBSY.
            if (!bbsy_s && !ssyn_s) begin
              BBSY_OUT <= 1'b1;
              cnt      <= '0;
              if (cur_npr) begin
                state   <= S_MASTER;
                granted <= 1'b1;
              end else begin
                state    <= S_VEC;
                vec_en   <= 1'b1;
                SACK_OUT <= 1'b0;
              end
            end
          end

          S_MASTER: begin
            // SACK lasts only the first MASTER cycle.
            SACK_OUT <= 1'b0;
            if (release_req) begin
              state    <= S_IDLE;
              BBSY_OUT <= 1'b0;
              granted  <= 1'b0;
              done     <= 1'b1;
            end
          end

          S_VEC: begin
            // Vector must settle on the data lines for DESKEW cycles.
            if (cnt < DSK_LAST) begin
              cnt <= cnt + 16'd1;
            end else if (!ssyn_s) begin
              state    <= S_INTR;
              INTR_OUT <= 1'b1;
              SACK_OUT <= 1'b1;
            end
          end

          S_INTR: begin
            SACK_OUT <= 1'b0;
            // CPU answers with SSYN once it has taken the vector.
            if (ssyn_s) begin
              state    <= S_IDLE;
              BBSY_OUT <= 1'b0;
              INTR_OUT <= 1'b0;
              vec_en   <= 1'b0;
              done     <= 1'b1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udisk_bus_acquire.sv
// Directed bench for udisk_bus_acquire: reset/pass-through table, then
// hand-written DMA, interrupt, timeout, collision and abort sequences.
module tb_udisk_bus_acquire;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_npr, req_intr, intr_level, release_req;
  logic [15:0] intr_vector;
  logic        BBSY_IN, SSYN_IN, INIT_IN, NPG_IN, BG4_IN, BG5_IN;
  logic        NPR_OUT, BR4_OUT, BR5_OUT, SACK_OUT, BBSY_OUT, INTR_OUT;
  logic        NPG_OUT, BG4_OUT, BG5_OUT;
  logic [15:0] vec_data;
  logic        vec_en, granted, done, timeout;

  always #5 CLK = ~CLK;

  udisk_bus_acquire #(.GRANT_TMO(20), .DESKEW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_npr(req_npr), .req_intr(req_intr), .intr_level(intr_level),
    .intr_vector(intr_vector), .release_req(release_req),
    .BBSY_IN(BBSY_IN), .SSYN_IN(SSYN_IN), .INIT_IN(INIT_IN),
    .NPG_IN(NPG_IN), .BG4_IN(BG4_IN), .BG5_IN(BG5_IN),
    .NPR_OUT(NPR_OUT), .BR4_OUT(BR4_OUT), .BR5_OUT(BR5_OUT),
    .SACK_OUT(SACK_OUT), .BBSY_OUT(BBSY_OUT), .INTR_OUT(INTR_OUT),
    .NPG_OUT(NPG_OUT), .BG4_OUT(BG4_OUT), .BG5_OUT(BG5_OUT),
    .vec_data(vec_data), .vec_en(vec_en), .granted(granted),
    .done(done), .timeout(timeout)
  );

  localparam logic [15:0] B_NPR  = 16'h0200;
  localparam logic [15:0] B_BR4  = 16'h0100;
  localparam logic [15:0] B_BR5  = 16'h0080;
  localparam logic [15:0] B_SACK = 16'h0040;
  localparam logic [15:0] B_BBSY = 16'h0020;
  localparam logic [15:0] B_INTR = 16'h0010;
  localparam logic [15:0] B_VEN  = 16'h0008;
  localparam logic [15:0] B_GNT  = 16'h0004;
  localparam logic [15:0] B_DONE = 16'h0002;
  localparam logic [15:0] B_TMO  = 16'h0001;

  int checks = 0;
  int errors = 0;

  // Cycle monitors for properties that must hold across whole sequences.
  int mon_br4 = 0;
  int mon_done = 0;
  int mon_npgout = 0;
  always @(negedge CLK) begin
    if (BR4_OUT) mon_br4 <= mon_br4 + 1;
    if (done)    mon_done <= mon_done + 1;
    if (NPG_OUT) mon_npgout <= mon_npgout + 1;
  end

  typedef struct {
    logic rst;
    logic npg;
    logic bg4;
    logic bg5;
    logic e_npg;
    logic e_bg4;
    logic e_bg5;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [15:0] outs();
    return {6'b0, NPR_OUT, BR4_OUT, BR5_OUT, SACK_OUT, BBSY_OUT, INTR_OUT,
            vec_en, granted, done, timeout};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %04h expected %04h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %b expected %b", nm, act, exp);
    end
  endtask

  // Tick until any output bit in mask equals val, bounded at 40 cycles.
  task automatic wait_out(input string nm, input logic [15:0] mask, input logic val);
    int n;
    n = 0;
    while ((|(outs() & mask)) !== val && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ((|(outs() & mask)) !== val) begin
      errors++;
      $display("FAIL %s actual no-event expected event within 40 cycles", nm);
    end
  endtask

  int n;
  int snap_br4, snap_done, snap_npg;

  initial begin
    RESET = 1'b1; req_npr = 1'b0; req_intr = 1'b0; intr_level = 1'b0;
    intr_vector = 16'h0; release_req = 1'b0;
    BBSY_IN = 1'b0; SSYN_IN = 1'b0; INIT_IN = 1'b0;
    NPG_IN = 1'b0; BG4_IN = 1'b0; BG5_IN = 1'b0;

    // ---- reset state and grant pass-through table ----
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      RESET = tbl[i].rst; NPG_IN = tbl[i].npg; BG4_IN = tbl[i].bg4; BG5_IN = tbl[i].bg5;
      tick();
      chk1($sformatf("tbl%0d_npg", i), NPG_OUT, tbl[i].e_npg);
      chk1($sformatf("tbl%0d_bg4", i), BG4_OUT, tbl[i].e_bg4);
      chk1($sformatf("tbl%0d_bg5", i), BG5_OUT, tbl[i].e_bg5);
      chk16($sformatf("tbl%0d_outs", i), outs(), 16'h0);
      chk16($sformatf("tbl%0d_vec", i), vec_data, 16'h0);
    end
    NPG_IN = 1'b0; BG4_IN = 1'b0; BG5_IN = 1'b0;
    repeat (3) tick();

    // ---- DMA tenure ----
    snap_npg = mon_npgout;
    req_npr = 1'b1; tick(); req_npr = 1'b0;
    chk16("dma_pend_only", outs(), 16'h0);
    tick();
    chk16("dma_npr_rise", outs(), B_NPR);
    repeat (5) tick();
    NPG_IN = 1'b1;
    tick(); tick();
    chk16("dma_npr_hold_sync", outs(), B_NPR);
    tick();
    chk16("dma_npr_to_sack", outs(), B_SACK);
    NPG_IN = 1'b0;
    wait_out("dma_wait_bbsy", B_BBSY, 1'b1);
    chk16("dma_master_first", outs(), B_SACK | B_BBSY | B_GNT);
    tick();
    chk16("dma_sack_drop", outs(), B_BBSY | B_GNT);
    tick();
    release_req = 1'b1; tick(); release_req = 1'b0;
    chk16("dma_done", outs(), B_DONE);
    tick();
    chk16("dma_all_zero", outs(), 16'h0);
    chk1("dma_npg_out_blocked", (mon_npgout - snap_npg) == 0, 1'b1);

    // ---- interrupt at BR5 ----
    snap_br4 = mon_br4;
    intr_level = 1'b1; intr_vector = 16'o000220;
    req_intr = 1'b1; tick(); req_intr = 1'b0;
    intr_vector = 16'hFFFF; intr_level = 1'b0;
    tick();
    chk16("intr_br5_rise", outs(), B_BR5);
    chk16("intr_vec_latched", vec_data, 16'o000220);
    BG4_IN = 1'b1; #1;
    chk1("intr_bg4_pass_hi", BG4_OUT, 1'b1);
    BG5_IN = 1'b1; #1;
    chk1("intr_bg5_blocked", BG5_OUT, 1'b0);
    BG4_IN = 1'b0; #1;
    chk1("intr_bg4_pass_lo", BG4_OUT, 1'b0);
    wait_out("intr_wait_sack", B_SACK, 1'b1);
    chk1("intr_br5_drop", BR5_OUT, 1'b0);
    BG5_IN = 1'b0;
    wait_out("intr_wait_vec", B_VEN, 1'b1);
    chk16("intr_vec_state", outs(), B_BBSY | B_VEN);
    n = 0;
    release_req = 1'b1;
    while (vec_en && !INTR_OUT && n < 40) begin
      n++;
      tick();
      release_req = 1'b0;
    end
    chk1("intr_deskew_min", n >= 8, 1'b1);
    chk16("intr_intr_state", outs() & ~B_SACK, B_BBSY | B_INTR | B_VEN);
    SSYN_IN = 1'b1;
    wait_out("intr_wait_done", B_DONE, 1'b1);
    chk16("intr_done", outs(), B_DONE);
    SSYN_IN = 1'b0;
    tick();
    chk16("intr_all_zero", outs(), 16'h0);
    chk1("intr_no_br4", (mon_br4 - snap_br4) == 0, 1'b1);
    repeat (3) tick();

    // ---- grant timeout ----
    req_npr = 1'b1; tick(); req_npr = 1'b0;
    tick();
    snap_done = mon_done;
    n = 0;
    while (NPR_OUT && n < 50) begin
      n++;
      tick();
    end
    chk16("tmo_npr_cycles", 16'(n), 16'd20);
    chk16("tmo_flag", outs(), B_TMO);
    tick();
    chk1("tmo_no_done", (mon_done - snap_done) == 0, 1'b1);
    chk1("tmo_sticky", timeout, 1'b1);
    req_npr = 1'b1; tick(); req_npr = 1'b0;
    tick();
    chk16("tmo_cleared_new_req", outs(), B_NPR);

    // ---- INIT while MASTER ----
    NPG_IN = 1'b1;
    wait_out("init_wait_sack", B_SACK, 1'b1);
    NPG_IN = 1'b0;
    wait_out("init_wait_bbsy", B_BBSY, 1'b1);
    tick();
    INIT_IN = 1'b1;
    tick(); tick();
    chk16("init_sync_latency", outs(), B_BBSY | B_GNT);
    tick();
    chk16("init_abort", outs(), 16'h0);
    INIT_IN = 1'b0;
    repeat (4) tick();
    chk16("init_stays_idle", outs(), 16'h0);

    // ---- collision: NPR first, then BR4 without a new pulse ----
    intr_level = 1'b0; intr_vector = 16'h1234;
    req_npr = 1'b1; req_intr = 1'b1; tick(); req_npr = 1'b0; req_intr = 1'b0;
    tick();
    chk16("coll_npr_first", outs(), B_NPR);
    NPG_IN = 1'b1;
    wait_out("coll_wait_sack", B_SACK, 1'b1);
    NPG_IN = 1'b0;
    wait_out("coll_wait_bbsy", B_BBSY, 1'b1);
    tick();
    release_req = 1'b1; tick(); release_req = 1'b0;
    chk16("coll_npr_done", outs(), B_DONE);
    tick();
    chk16("coll_br4_follows", outs(), B_BR4);
    chk16("coll_vec", vec_data, 16'h1234);

    // ---- RESET in VEC ----
    BG4_IN = 1'b1;
    wait_out("rst_wait_sack", B_SACK, 1'b1);
    BG4_IN = 1'b0;
    wait_out("rst_wait_vec", B_VEN, 1'b1);
    tick();
    #2;
    RESET = 1'b1;
    #1;
    chk16("rst_async_outs", outs(), 16'h0);
    chk16("rst_async_vec", vec_data, 16'h0);
    BG4_IN = 1'b1; #1;
    chk1("rst_bg4_follow", BG4_OUT, 1'b1);
    BG4_IN = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    repeat (3) tick();
    chk16("rst_idle_after", outs(), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
